ps2_transmitter: RTL and testbench

Host-to-device PS/2 transmitter that sends command bytes (LED set, reset 0xFF, enable reporting 0xF4, …) to a keyboard or mouse. It is the companion to the receive-only PS/2 controller: both share the open-drain PS/2 clock/data pair. This block drives the lines low only while a transmission is in progress and releases them otherwise, so the receiver can monitor the pair at all times. Software reaches it as an io_bus slave.

---
 rtl/ps2_transmitter_if.sv | 11 +
 rtl/ps2_transmitter.sv | 140 ++++++++++++++
 tb/tb_ps2_transmitter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_transmitter_if.sv
// ps2_transmitter_if: io_bus register interface.
// Ports: write_en/read_en strobes, address, write_data from the master; read_data from the slave.
interface io_bus_interface;
  logic        write_en;
  logic        read_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  modport master (output write_en, read_en, address, write_data, input read_data);
  modport slave (input write_en, read_en, address, write_data, output read_data);
endinterface

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command byte transmitter, io_bus slave.
// Ports: clk, reset_n (async active-low); io_bus slave (STATUS at BASE_ADDRESS, TX at +8);
// tx_done end-of-transfer pulse; ps2_clk/ps2_data raw pins in; ps2_clk_oe/ps2_data_oe pull-low enables out.
module ps2_transmitter #(
  parameter logic [31:0] BASE_ADDRESS   = 32'd0,
  parameter int          INHIBIT_CYCLES = 5000,
  parameter int          TIMEOUT_CYCLES = 750000
) (
  input  logic clk,
  input  logic reset_n,
  io_bus_interface.slave io_bus,
  output logic tx_done,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic ps2_clk_oe,
  output logic ps2_data_oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] TX_REG = BASE_ADDRESS + 32'd8;
  typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, START, DATA, PARITY, STOP, ACK} state_t;
  state_t state, state_n;
  logic [1:0] clk_sr, data_sr;
  logic clk_prev, fall, tx_wr;
  logic [IW-1:0] inh_cnt, inh_n;
  logic [TW-1:0] to_cnt, to_n;
  logic [3:0] bit_cnt, bit_n;
  logic [7:0] tx_byte, byte_n;
  logic parity, par_n, ack_error, err_n;
  logic clk_oe_n, data_oe_n, done_n;
  logic [31:0] rd_n;
  logic unused_ok;
  assign unused_ok = &{1'b0, io_bus.read_en, io_bus.write_data[31:8]};
  assign fall = !clk_sr[1] && clk_prev;
  assign tx_wr = io_bus.write_en && io_bus.address == TX_REG;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      clk_sr <= 2'b11;
      data_sr <= 2'b11;
      clk_prev <= 1'b1;
      inh_cnt <= '0;
      to_cnt <= '0;
      bit_cnt <= '0;
      tx_byte <= '0;
      parity <= 1'b0;
      ack_error <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done <= 1'b0;
      io_bus.read_data <= '0;
    end else begin
      state <= state_n;
      clk_sr <= {clk_sr[0], ps2_clk};
      data_sr <= {data_sr[0], ps2_data};
      clk_prev <= clk_sr[1];
      inh_cnt <= inh_n;
      to_cnt <= to_n;
      bit_cnt <= bit_n;
      tx_byte <= byte_n;
      parity <= par_n;
      ack_error <= err_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_data_oe <= data_oe_n;
      tx_done <= done_n;
      io_bus.read_data <= rd_n;
    end
  end
  always_comb begin
    state_n = state;
    inh_n = inh_cnt;
    to_n = to_cnt;
    bit_n = bit_cnt;
    byte_n = tx_byte;
    par_n = parity;
    err_n = ack_error;
    data_oe_n = ps2_data_oe;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        data_oe_n = 1'b0;
        if (tx_wr) begin
          byte_n = io_bus.write_data[7:0];
          par_n = ~^io_bus.write_data[7:0];
          err_n = 1'b0;
          inh_n = '0;
          state_n = INHIBIT;
        end
      end
      INHIBIT: begin
        inh_n = inh_cnt == IW'(INHIBIT_CYCLES - 1) ? '0 : inh_cnt + 1'b1;
        data_oe_n = inh_cnt == IW'(INHIBIT_CYCLES - 1);
        state_n = inh_cnt == IW'(INHIBIT_CYCLES - 1) ? REQUEST : INHIBIT;
      end
      REQUEST: begin
        to_n = '0;
        state_n = START;
      end
      default: begin
        // Device clock stalled too long: abandon the frame and release both lines.
        if (to_cnt == TW'(TIMEOUT_CYCLES)) begin
          to_n = '0;
          data_oe_n = 1'b0;
          err_n = 1'b1;
          done_n = 1'b1;
          state_n = IDLE;
        end else if (fall) begin
          to_n = '0;
          case (state)
            START: begin
              data_oe_n = !tx_byte[0];
              bit_n = 4'd1;
              state_n = DATA;
            end
            DATA: begin
              data_oe_n = bit_cnt == 4'd8 ? !parity : !tx_byte[bit_cnt[2:0]];
              bit_n = bit_cnt + 4'd1;
              state_n = bit_cnt == 4'd8 ? PARITY : DATA;
            end
            PARITY: begin
              data_oe_n = 1'b0;
              state_n = STOP;
            end
            STOP: state_n = ACK;
            ACK: begin
              err_n = ack_error | data_sr[1];
              done_n = 1'b1;
              state_n = IDLE;
            end
            default: state_n = state;
          endcase
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
    endcase
    clk_oe_n = state_n == INHIBIT || state_n == REQUEST;
    rd_n = io_bus.address == BASE_ADDRESS ? {30'b0, ack_error, state != IDLE} : '0;
  end
endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: self-checking bench with a PS/2 device model on the open-drain pair.
module tb_ps2_transmitter;
  localparam int INH = 50;
  localparam int TMO = 600;
  localparam int HP = 20;
  logic clk = 1'b0, reset_n = 1'b0;
  logic tx_done, ps2_clk_oe, ps2_data_oe, ps2_clk, ps2_data;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0;
  int n_chk = 0, n_fail = 0, done_cnt = 0;
  io_bus_interface bus();
  ps2_transmitter #(.BASE_ADDRESS(32'd0), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .io_bus(bus), .tx_done(tx_done),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe));
  assign ps2_clk = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data = !(ps2_data_oe || dev_data_low);
  always #5 clk = ~clk;
  always @(negedge clk) if (tx_done) done_cnt++;
  typedef struct {
    logic [7:0]  b;
    bit          ack;
    logic        exp_par;
    logic [31:0] exp_st;
  } vec_t;
  vec_t vecs[5];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic bus_write(input logic [7:0] v);
    @(negedge clk);
    bus.address = 32'd8;
    bus.write_data = {24'hABCDEF, v};
    bus.write_en = 1'b1;
    @(negedge clk);
    bus.write_en = 1'b0;
    bus.address = 32'd4;
  endtask
  task automatic read_status(output logic [31:0] v);
    @(negedge clk);
    bus.address = 32'd0;
    bus.read_en = 1'b1;
    @(negedge clk);
    v = bus.read_data;
    bus.read_en = 1'b0;
    bus.address = 32'd4;
  endtask
  task automatic wait_req(output int n, output bit clk_held);
    n = 0;
    clk_held = 1'b1;
    while (!ps2_data_oe && n < INH * 4) begin
      clk_held &= ps2_clk_oe;
      @(negedge clk);
      n++;
    end
  endtask
  task automatic wait_start(output int t);
    t = 0;
    while (!(ps2_clk && !ps2_data) && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic clock_dev(input int np, input bit ack, output logic [9:0] got);
    int t;
    got = '1;
    wait_start(t);
    chk("start_seen", t < 100, 1);
    repeat (HP) @(negedge clk);
    for (int k = 0; k < np; k++) begin
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k < 10) got[k] = ps2_data;
      if (k == 10 && ack) dev_data_low = 1'b1;
      if (k == 11) dev_data_low = 1'b0;
      repeat (HP) @(negedge clk);
    end
  endtask
  task automatic xfer(input logic [7:0] b, input bit ack, input logic exp_par, input logic [31:0] exp_st);
    int n, d0;
    bit held;
    logic [9:0] got;
    logic [31:0] st;
    d0 = done_cnt;
    bus_write(b);
    wait_req(n, held);
    chk("inhibit_len", n, INH);
    chk("inhibit_clk_low", held, 1);
    clock_dev(12, ack, got);
    chk("data_bits", got[7:0], b);
    chk("parity_bit", got[8], exp_par);
    chk("stop_bit", got[9], 1);
    repeat (5) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
    read_status(st);
    chk("status_after", st, exp_st);
  endtask
  initial begin
    int n, d0;
    bit held;
    logic [9:0] got;
    logic [31:0] st;
    logic [7:0] rb;
    bit ra;
    vecs[0] = '{8'hFF, 1'b1, 1'b1, 32'h0};
    vecs[1] = '{8'hF4, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{8'h00, 1'b0, 1'b1, 32'h2};
    vecs[3] = '{8'h81, 1'b1, 1'b1, 32'h0};
    vecs[4] = '{8'h7F, 1'b1, 1'b0, 32'h0};
    bus.write_en = 1'b0;
    bus.read_en = 1'b0;
    bus.address = 32'd4;
    bus.write_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_read_data", bus.read_data, 0);
    reset_n = 1'b1;
    read_status(st);
    chk("status_idle", st, 0);
    @(negedge clk);
    bus.address = 32'd8;
    @(negedge clk);
    chk("tx_reg_read", bus.read_data, 0);
    bus.address = 32'd4;
    for (int i = 0; i < 5; i++) xfer(vecs[i].b, vecs[i].ack, vecs[i].exp_par, vecs[i].exp_st);
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom);
      ra = 1'($urandom);
      xfer(rb, ra, ($countones(rb) % 2) == 0, ra ? 32'h0 : 32'h2);
    end
    d0 = done_cnt;
    bus_write(8'h55);
    wait_req(n, held);
    wait_start(n);
    n = 0;
    while (!tx_done && n < TMO + 50) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_len", (n >= TMO && n <= TMO + 2), 1);
    chk("timeout_clk_oe", ps2_clk_oe, 0);
    chk("timeout_data_oe", ps2_data_oe, 0);
    repeat (3) @(negedge clk);
    chk("timeout_done", done_cnt - d0, 1);
    read_status(st);
    chk("timeout_status", st, 32'h2);
    xfer(8'hED, 1'b1, 1'b1, 32'h0);
    d0 = done_cnt;
    bus_write(8'hAA);
    repeat (10) @(negedge clk);
    bus_write(8'h11);
    read_status(st);
    chk("busy_inhibit", st, 32'h1);
    wait_req(n, held);
    clock_dev(12, 1'b1, got);
    chk("ignored_write_bits", got[7:0], 8'hAA);
    chk("ignored_write_par", got[8], 1);
    repeat (5) @(negedge clk);
    chk("ignored_write_done", done_cnt - d0, 1);
    read_status(st);
    chk("ignored_write_status", st, 0);
    bus_write(8'h00);
    wait_req(n, held);
    clock_dev(4, 1'b1, got);
    chk("mid_data_oe", ps2_data_oe, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_clk_oe", ps2_clk_oe, 0);
    chk("async_rst_data_oe", ps2_data_oe, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    read_status(st);
    chk("post_rst_status", st, 0);
    xfer(8'h3C, 1'b1, 1'b1, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
